vec_unscale: RTL and testbench

Divides a three-lane signed Q(32−Q_BITS).Q_BITS vector by a scalar: out[i] = (x[i] << Q_BITS) / a. It is the inverse of the vector-scale stage and is used wherever a scaled ray or normal must be brought back, for example perspective divide or dividing by a length. It pops operands from an upstream FIFO and computes all three quotients in parallel with a bit-serial restoring divider. Results are pushed into an internal fifo_array (32-bit, depth 1024, array size 3) so downstream stages read through the standard empty/rd_en interface.

---
 rtl/vec_unscale_if.sv | 19 +
 rtl/vec_unscale.sv | 128 ++++++++++++
 tb/tb_vec_unscale.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/vec_unscale_if.sv
// vec_unscale_if: upstream operand FIFO head plus downstream result FIFO read port.
interface vec_unscale_if;
    logic [2:0][31:0] x;
    logic [31:0]      a;
    logic             in_empty;
    logic             in_rd_en;
    logic [2:0][31:0] out;
    logic             out_empty;
    logic             out_rd_en;
    logic             dz_flag;
    modport slave (
        input  x, a, in_empty, out_rd_en,
        output in_rd_en, out, out_empty, dz_flag
    );
    modport master (
        output x, a, in_empty, out_rd_en,
        input  in_rd_en, out, out_empty, dz_flag
    );
endinterface

// File: rtl/vec_unscale.sv
// vec_unscale: three-lane signed fixed-point divide by a scalar using a bit-serial restoring
// divider, with results queued in an internal first-word-fall-through FIFO.
module vec_unscale #(
    parameter int Q_BITS           = 16,
    parameter int FIFO_BUFFER_SIZE = 1024
) (
    input logic          clock,
    input logic          reset,
    vec_unscale_if.slave bus
);
    localparam int DW   = 32 + Q_BITS;
    localparam int CW   = $clog2(DW);
    localparam int AW   = $clog2(FIFO_BUFFER_SIZE);
    localparam int CNTW = AW + 1;
    localparam logic [31:0] MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] MIN = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, DIV, FIX, WRITE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q;
    logic [31:0]        div_q;
    logic               a_zero_q, dz_q;
    logic [2:0]         neg_q, nz_q;
    logic [2:0][33:0]   rem_q, rem_d;
    logic [2:0][DW-1:0] dq_q, dq_d;
    logic [2:0][31:0]   res_q, res_d, mag;
    logic [2:0][34:0]   trial;
    logic [2:0]         ge, sat_pos, sat_neg;
    logic               out_wr_en, out_full, out_rd;

    logic [2:0][31:0] mem [FIFO_BUFFER_SIZE];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]  count_q;

    // dq holds the shifting dividend; quotient bits enter at the bottom as dividend bits leave the top
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            trial[i]   = {rem_q[i], dq_q[i][DW-1]};
            ge[i]      = trial[i] >= 35'(div_q);
            rem_d[i]   = ge[i] ? 34'(trial[i] - 35'(div_q)) : 34'(trial[i]);
            dq_d[i]    = {dq_q[i][DW-2:0], ge[i]};
            mag[i]     = bus.x[i][31] ? -bus.x[i] : bus.x[i];
            sat_pos[i] = |dq_q[i][DW-1:31];
            sat_neg[i] = |dq_q[i][DW-1:32] || (dq_q[i][31] && |dq_q[i][30:0]);
            res_d[i]   = a_zero_q ? (nz_q[i] ? (neg_q[i] ? MIN : MAX) : 32'h0)
                       : (!neg_q[i] && sat_pos[i]) ? MAX
                       : (neg_q[i] && sat_neg[i]) ? MIN
                       : neg_q[i] ? -dq_q[i][31:0] : dq_q[i][31:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.in_rd_en = 1'b0;
        out_wr_en    = 1'b0;
        case (state_q)
            IDLE: if (!bus.in_empty) begin
                bus.in_rd_en = 1'b1;
                state_d      = DIV;
            end
            DIV: if (cnt_q == '0) state_d = FIX;
            FIX: state_d = WRITE;
            WRITE: if (!out_full) begin
                out_wr_en = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            a_zero_q <= 1'b0;
            dz_q     <= 1'b0;
            neg_q    <= '0;
            nz_q     <= '0;
            rem_q    <= '0;
            dq_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q <= state_d;
            if (bus.in_rd_en) begin
                cnt_q    <= CW'(DW - 1);
                div_q    <= bus.a[31] ? -bus.a : bus.a;
                a_zero_q <= bus.a == '0;
                rem_q    <= '0;
                for (int i = 0; i < 3; i++) begin
                    neg_q[i] <= bus.x[i][31] ^ bus.a[31];
                    nz_q[i]  <= bus.x[i] != '0;
                    dq_q[i]  <= {mag[i], {Q_BITS{1'b0}}};
                end
            end else if (state_q == DIV) begin
                rem_q <= rem_d;
                dq_q  <= dq_d;
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end else if (state_q == FIX) begin
                res_q <= res_d;
                dz_q  <= a_zero_q;
            end
        end
    end

    assign out_full      = count_q == CNTW'(FIFO_BUFFER_SIZE);
    assign out_rd        = bus.out_rd_en && count_q != '0;
    assign bus.out_empty = count_q == '0;
    assign bus.out       = mem[rd_ptr_q];
    assign bus.dz_flag   = out_wr_en && dz_q;

    always_ff @(posedge clock) begin
        if (out_wr_en) mem[wr_ptr_q] <= res_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (out_wr_en) wr_ptr_q <= wr_ptr_q == AW'(FIFO_BUFFER_SIZE - 1) ? '0 : wr_ptr_q + 1'b1;
            if (out_rd) rd_ptr_q <= rd_ptr_q == AW'(FIFO_BUFFER_SIZE - 1) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CNTW'(out_wr_en) - CNTW'(out_rd);
        end
    end
endmodule

// File: tb/tb_vec_unscale.sv
// tb_vec_unscale: randomized and directed stimulus checked every cycle against an arithmetic
// model of the divide, pop/write timing and output FIFO occupancy.
module tb_vec_unscale;
    localparam int DEPTH = 2;
    localparam int LAT   = 50;

    typedef struct {logic [2:0][31:0] x; logic [31:0] a;} vec_t;
    typedef struct {logic [2:0][31:0] o; logic dz;} res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    vec_t inq[$];
    res_t outq[$];
    res_t cur;
    logic inflight = 1'b0;
    int   t_pop = 0;
    logic started = 1'b0;

    vec_unscale_if bus();
    vec_unscale #(.Q_BITS(16), .FIFO_BUFFER_SIZE(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] ref_div(logic [31:0] x, logic [31:0] a);
        longint n = longint'($signed(x)) * 65536;
        longint d = longint'($signed(a));
        longint q;
        if (d == 0) return n > 0 ? 32'h7FFFFFFF : n < 0 ? 32'h80000000 : 32'h0;
        q = n / d;
        if (q > 64'sd2147483647) return 32'h7FFFFFFF;
        if (q < -64'sd2147483648) return 32'h80000000;
        return q[31:0];
    endfunction

    initial begin
        bus.in_empty  = 1'b1;
        bus.x         = '0;
        bus.a         = '0;
        forever begin
            @(posedge clock);
            #1;
            bus.in_empty = inq.size() == 0;
            if (inq.size() > 0) begin
                bus.x = inq[0].x;
                bus.a = inq[0].a;
            end
        end
    end

    // Scoreboard: a vector popped at T is written at the first cycle >= T+LAT with room in the FIFO
    initial forever begin
        logic exp_rd, exp_wr;
        vec_t v;
        @(negedge clock);
        if (started) begin
            exp_rd = !inflight && !bus.in_empty;
            exp_wr = inflight && cyc >= t_pop + LAT && outq.size() < DEPTH;
            check("in_rd_en", bus.in_rd_en, exp_rd);
            check("out_wr_en", dut.out_wr_en, exp_wr);
            check("dz_flag", bus.dz_flag, exp_wr && cur.dz);
            check("out_empty", bus.out_empty, outq.size() == 0);
            if (bus.out_rd_en && outq.size() > 0) begin
                for (int i = 0; i < 3; i++) check($sformatf("out[%0d]", i), bus.out[i], outq[0].o[i]);
                void'(outq.pop_front());
            end
            if (exp_wr) begin
                outq.push_back(cur);
                inflight = 1'b0;
            end
        end
        if (bus.in_rd_en && inq.size() > 0) begin
            v = inq.pop_front();
            for (int i = 0; i < 3; i++) cur.o[i] = ref_div(v.x[i], v.a);
            cur.dz   = v.a == 0;
            inflight = 1'b1;
            t_pop    = cyc;
        end
        if (reset) begin
            inflight = 1'b0;
            outq.delete();
            started = 1'b1;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(logic [31:0] x0, logic [31:0] x1, logic [31:0] x2, logic [31:0] a);
        vec_t v;
        v.x[0] = x0;
        v.x[1] = x1;
        v.x[2] = x2;
        v.a    = a;
        inq.push_back(v);
    endtask

    task automatic read_lit(string name, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
        int k = 0;
        @(negedge clock);
        while (bus.out_empty && k < 200) begin
            @(negedge clock);
            k++;
        end
        check({name, "_ready"}, bus.out_empty, 1'b0);
        check({name, "_0"}, bus.out[0], e0);
        check({name, "_1"}, bus.out[1], e1);
        check({name, "_2"}, bus.out[2], e2);
        step(1);
        bus.out_rd_en = 1'b1;
        step(1);
        bus.out_rd_en = 1'b0;
    endtask

    task automatic drain(int budget);
        int k = 0;
        bus.out_rd_en = 1'b1;
        while (!(inq.size() == 0 && !inflight && outq.size() == 0) && k < budget) begin
            step(1);
            k++;
        end
        check("drain_done", k < budget, 1'b1);
        bus.out_rd_en = 1'b0;
        step(2);
    endtask

    function automatic logic [31:0] rnd_signed(logic [31:0] m);
        logic [31:0] v = $urandom_range(0, 1) ? $urandom() & m : -($urandom() & m);
        return v;
    endfunction

    initial begin
        int k;
        bus.out_rd_en = 1'b0;
        check("pin_trunc", ref_div(32'hFFFF0000, 32'h00030000), 32'hFFFFAAAB);
        check("pin_sat", ref_div(32'h40000000, 32'h00000100), 32'h7FFFFFFF);
        check("pin_dz_neg", ref_div(32'hFFFB0000, 32'h0), 32'h80000000);
        check("pin_min_exact", ref_div(32'h80000000, 32'h00010000), 32'h80000000);
        step(3);
        reset = 1'b0;
        step(2);

        push(32'h00020000, 32'hFFFD0000, 32'h00008000, 32'h00020000);
        read_lit("basic", 32'h00010000, 32'hFFFE8000, 32'h00004000);
        push(32'h00010000, 32'hFFFF0000, 32'h00000001, 32'h00030000);
        read_lit("trunc", 32'h00005555, 32'hFFFFAAAB, 32'h00000000);

        push(32'h00050000, 32'hFFFB0000, 32'h0, 32'h0);
        k = 0;
        @(negedge clock);
        while (!dut.out_wr_en && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("dz_wr_seen", dut.out_wr_en, 1'b1);
        check("dz_flag_lit", bus.dz_flag, 1'b1);
        step(1);
        read_lit("divzero", 32'h7FFFFFFF, 32'h80000000, 32'h00000000);

        push(32'h40000000, 32'hC0000000, 32'h80000000, 32'h00000100);
        read_lit("sat", 32'h7FFFFFFF, 32'h80000000, 32'h80000000);
        push(32'h00010000, 32'hFFFF8000, 32'h80000000, 32'h00010000);
        read_lit("minexact", 32'h00010000, 32'hFFFF8000, 32'h80000000);

        for (int i = 0; i < 3; i++) push(rnd_signed(32'h00FFFFFF), rnd_signed(32'h0FFFFFFF), $urandom(), rnd_signed(32'h0007FFFF));
        step(3 * 51 + 15);
        drain(400);

        for (int i = 0; i < 4; i++) push($urandom(), rnd_signed(32'h000FFFFF), 32'h0, rnd_signed(32'h00FFFFFF) | 32'h1);
        drain(600);

        push(32'h00070000, 32'h00070000, 32'h00070000, 32'h00010000);
        push(32'h00030000, 32'h0, 32'h0, 32'h00010000);
        k = 0;
        @(negedge clock);
        while (!bus.in_rd_en && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("rst_first_pop", bus.in_rd_en, 1'b1);
        step(20);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clock);
        check("rst_out_empty", bus.out_empty, 1'b1);
        check("rst_repop", bus.in_rd_en, 1'b1);
        step(1);
        read_lit("after_rst", 32'h00030000, 32'h0, 32'h0);
        drain(200);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0: a = 32'h0;
                1, 2: a = rnd_signed(32'h000000FF) | 32'h1;
                3: a = $urandom();
                default: a = rnd_signed(32'h0007FFFF) | 32'h1;
            endcase
            push($urandom_range(0, 9) == 0 ? 32'h80000000 : $urandom(), rnd_signed(32'h0003FFFF), $urandom_range(0, 5) == 0 ? 32'h0 : rnd_signed(32'h00FFFFFF), a);
        end
        k = 0;
        while (!(inq.size() == 0 && !inflight) && k < 4000) begin
            bus.out_rd_en = $urandom_range(0, 2) == 0;
            step(1);
            k++;
        end
        check("random_done", k < 4000, 1'b1);
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
